// File: rtl/inst_align_buffer.sv
// inst_align_buffer: fetch-to-decode realignment FIFO of 16-bit parcels presenting one RV32IC instruction per handshake
module inst_align_buffer #(
  parameter int          FETCH_W  = 32,
  parameter int          DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [31:0]                   flush_pc,
  input  logic                          fetch_valid,
  output logic                          fetch_ready,
  input  logic [FETCH_W-1:0]            fetch_data,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [31:0]                   inst_data,
  output logic                          inst_compressed,
  output logic [31:0]                   inst_pc,
  output logic [$clog2(DEPTH_HW+1)-1:0] count
);
  localparam int NP = FETCH_W / 16;
  localparam int PW = $clog2(DEPTH_HW);
  localparam int CW = $clog2(DEPTH_HW + 1);
  localparam int SW = (NP > 1) ? $clog2(NP) : 1;
  logic [15:0]   mem [DEPTH_HW];
  logic [PW-1:0] head, tail;
  logic [31:0]   head_pc;
  logic [SW-1:0] skip;
  logic [15:0]   h0, h1;
  logic          push, pop;
  logic [CW-1:0] push_n, pop_n;
  assign h0              = mem[head];
  assign h1              = mem[head + PW'(1)];
  assign inst_compressed = h0[1:0] != 2'b11;
  assign inst_valid      = inst_compressed ? (count != '0) : (count >= CW'(2));
  assign inst_data       = inst_compressed ? {16'h0, h0} : {h1, h0};
  assign inst_pc         = head_pc;
  assign fetch_ready     = count <= CW'(DEPTH_HW - NP);
  assign push            = fetch_valid & fetch_ready & ~flush;
  assign pop             = inst_valid & inst_ready & ~flush;
  assign push_n          = push ? CW'(NP) - CW'(skip) : '0;
  assign pop_n           = pop ? (inst_compressed ? CW'(1) : CW'(2)) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      head    <= '0;
      tail    <= '0;
      head_pc <= RESET_PC;
      skip    <= '0;
    end else if (flush) begin
      count   <= '0;
      head    <= '0;
      tail    <= '0;
      head_pc <= {flush_pc[31:1], 1'b0};
      skip    <= flush_pc[SW:1];
    end else begin
      count   <= count + push_n - pop_n;
      head    <= head + PW'(pop_n);
      tail    <= tail + PW'(push_n);
      head_pc <= head_pc + (32'(pop_n) << 1);
      if (push) skip <= '0;
    end
  end
  // parcels below skip belong to the halfwords before an odd redirect target
  always_ff @(posedge clk) begin
    if (push & ~reset)
      for (int i = 0; i < NP; i++)
        if (i >= int'(skip)) mem[PW'(int'(tail) + i - int'(skip))] <= fetch_data[16*i +: 16];
  end
endmodule
